// File: rtl/rename_regfile.sv
// ---------------------------------------------------------------------------
// rename_regfile
//
// Architectural register file with a per-register rename tag.
// Each non-zero register holds a data word, a busy bit and the ROB nick of
// its youngest in-flight producer. The ROB renames destinations through the
// nick port and retires results through the commit port. A commit releases
// the tag only if its nick still owns the register. Decode reads two sources
// combinationally. Each read returns either a ready value (nick==0) or the
// nick of the pending producer.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   When defined, a commit that would release a source register is forwarded
//   to the read ports in the same cycle.
//
// Ports:
//   clk             clock
//   rst             synchronous active-low reset
//   rdy             global enable; state holds while low, reads stay live
//   iROB_clr        flush: drop every pending tag
//   iROB_nick_en    rename request
//   iROB_nick       nick allocated to the destination
//   iROB_nick_regnm destination register name
//   iROB_en         commit write
//   iROB_rd_regnm   committed register name
//   iROB_rd_dt      committed value
//   iROB_rd_nick    nick of the committing entry
//   iID_rs1_regnm   source 1 name
//   iID_rs2_regnm   source 2 name
//   oRS1_dt/nick    source 1 value / pending producer (0 when ready)
//   oRS2_dt/nick    source 2 value / pending producer (0 when ready)
// ---------------------------------------------------------------------------
module rename_regfile #(
    parameter int DATA_W  = 32,
    parameter int REG_NUM = 32,
    parameter int NICK_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              iROB_clr,
    input  logic              iROB_nick_en,
    input  logic [NICK_W-1:0] iROB_nick,
    input  logic [4:0]        iROB_nick_regnm,
    input  logic              iROB_en,
    input  logic [4:0]        iROB_rd_regnm,
    input  logic [DATA_W-1:0] iROB_rd_dt,
    input  logic [NICK_W-1:0] iROB_rd_nick,
    input  logic [4:0]        iID_rs1_regnm,
    input  logic [4:0]        iID_rs2_regnm,
    output logic [DATA_W-1:0] oRS1_dt,
    output logic [NICK_W-1:0] oRS1_nick,
    output logic [DATA_W-1:0] oRS2_dt,
    output logic [NICK_W-1:0] oRS2_nick
);

    logic [DATA_W-1:0] r_data [REG_NUM];
    logic [NICK_W-1:0] r_tag  [REG_NUM];
    logic [REG_NUM-1:0] r_busy;

    // Source read: x0 and out-of-range names read as a ready zero.
    function automatic logic [NICK_W+DATA_W-1:0] f_read(input logic [4:0] s);
        logic [DATA_W-1:0] v_dt;
        logic [NICK_W-1:0] v_nick;
        v_dt   = '0;
        v_nick = '0;
        if (rst && (s != 5'd0) && (int'(s) < REG_NUM)) begin
            v_dt   = r_data[s];
            v_nick = r_busy[s] ? r_tag[s] : '0;
`ifdef REGFILE_BYPASS_EN
            // Forward only a commit that would actually release the tag.
            // A stale commit leaves the younger producer's nick visible.
            if (iROB_en && (iROB_rd_regnm == s) && r_busy[s] &&
                (r_tag[s] == iROB_rd_nick)) begin
                v_dt   = iROB_rd_dt;
                v_nick = '0;
            end
`endif
        end
        return {v_nick, v_dt};
    endfunction

    always_comb begin
        {oRS1_nick, oRS1_dt} = f_read(iID_rs1_regnm);
        {oRS2_nick, oRS2_dt} = f_read(iID_rs2_regnm);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                r_data[i] <= '0;
                r_tag[i]  <= '0;
                r_busy[i] <= 1'b0;
            end
        end else if (rdy) begin
            // x0 is never touched, so the loop starts at 1.
            for (int i = 1; i < REG_NUM; i++) begin
                // Commit data always lands, even during a flush or when a
                // younger writer already owns the tag.
                if (iROB_en && (iROB_rd_regnm == 5'(i)))
                    r_data[i] <= iROB_rd_dt;

                if (iROB_clr) begin
                    r_busy[i] <= 1'b0;
                    r_tag[i]  <= '0;
                end else if (iROB_nick_en && (iROB_nick_regnm == 5'(i))) begin
                    r_busy[i] <= 1'b1;
                    r_tag[i]  <= iROB_nick;
                end else if (iROB_en && (iROB_rd_regnm == 5'(i)) &&
                             r_busy[i] && (r_tag[i] == iROB_rd_nick)) begin
                    r_busy[i] <= 1'b0;
                    r_tag[i]  <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_rename_regfile.sv
module tb_rename_regfile;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        iROB_clr;
    logic        iROB_nick_en;
    logic [4:0]  iROB_nick;
    logic [4:0]  iROB_nick_regnm;
    logic        iROB_en;
    logic [4:0]  iROB_rd_regnm;
    logic [31:0] iROB_rd_dt;
    logic [4:0]  iROB_rd_nick;
    logic [4:0]  iID_rs1_regnm;
    logic [4:0]  iID_rs2_regnm;
    logic [31:0] oRS1_dt;
    logic [4:0]  oRS1_nick;
    logic [31:0] oRS2_dt;
    logic [4:0]  oRS2_nick;

    rename_regfile #(.DATA_W(32), .REG_NUM(32), .NICK_W(5)) dut (
        .clk             (clk),
        .rst             (rst),
        .rdy             (rdy),
        .iROB_clr        (iROB_clr),
        .iROB_nick_en    (iROB_nick_en),
        .iROB_nick       (iROB_nick),
        .iROB_nick_regnm (iROB_nick_regnm),
        .iROB_en         (iROB_en),
        .iROB_rd_regnm   (iROB_rd_regnm),
        .iROB_rd_dt      (iROB_rd_dt),
        .iROB_rd_nick    (iROB_rd_nick),
        .iID_rs1_regnm   (iID_rs1_regnm),
        .iID_rs2_regnm   (iID_rs2_regnm),
        .oRS1_dt         (oRS1_dt),
        .oRS1_nick       (oRS1_nick),
        .oRS2_dt         (oRS2_dt),
        .oRS2_nick       (oRS2_nick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference state: value, owner nick (0 = none) per register.
    logic [31:0] m_data  [32];
    logic [4:0]  m_owner [32];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // What decode should see for source s given current inputs.
    task automatic m_read(input logic [4:0] s, output logic [31:0] dt, output logic [4:0] nick);
        dt = 32'd0;
        nick = 5'd0;
        if (rst === 1'b1 && s != 0) begin
            dt   = m_data[s];
            nick = m_owner[s];
`ifdef REGFILE_BYPASS_EN
            if (iROB_en && iROB_rd_regnm == s && m_owner[s] != 0 && m_owner[s] == iROB_rd_nick) begin
                dt   = iROB_rd_dt;
                nick = 5'd0;
            end
`endif
        end
    endtask

    // Apply one clock edge's worth of architectural effects; later steps
    // override earlier ones, which encodes clr > rename > commit-release.
    task automatic m_update();
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                m_data[i]  = 32'd0;
                m_owner[i] = 5'd0;
            end
        end else if (rdy) begin
            if (iROB_en && iROB_rd_regnm != 0) begin
                m_data[iROB_rd_regnm] = iROB_rd_dt;
                if (m_owner[iROB_rd_regnm] != 0 && m_owner[iROB_rd_regnm] == iROB_rd_nick)
                    m_owner[iROB_rd_regnm] = 5'd0;
            end
            if (iROB_nick_en && iROB_nick_regnm != 0)
                m_owner[iROB_nick_regnm] = iROB_nick;
            if (iROB_clr)
                for (int i = 0; i < 32; i++) m_owner[i] = 5'd0;
        end
    endtask

    task automatic idle();
        rdy = 1'b1;
        iROB_clr = 1'b0;
        iROB_nick_en = 1'b0;
        iROB_nick = 5'd0;
        iROB_nick_regnm = 5'd0;
        iROB_en = 1'b0;
        iROB_rd_regnm = 5'd0;
        iROB_rd_dt = 32'd0;
        iROB_rd_nick = 5'd0;
    endtask

    // Check both read ports against the model, then take one clock edge.
    task automatic tick();
        logic [31:0] e1d, e2d;
        logic [4:0]  e1n, e2n;
        #1;
        m_read(iID_rs1_regnm, e1d, e1n);
        m_read(iID_rs2_regnm, e2d, e2n);
        chk("rs1_dt",   oRS1_dt,   e1d);
        chk("rs1_nick", oRS1_nick, e1n);
        chk("rs2_dt",   oRS2_dt,   e2d);
        chk("rs2_nick", oRS2_nick, e2n);
        @(posedge clk);
        m_update();
        @(negedge clk);
    endtask

    task automatic rename(input logic [4:0] r, input logic [4:0] n);
        iROB_nick_en = 1'b1; iROB_nick_regnm = r; iROB_nick = n;
    endtask

    task automatic commit(input logic [4:0] r, input logic [4:0] n, input logic [31:0] d);
        iROB_en = 1'b1; iROB_rd_regnm = r; iROB_rd_nick = n; iROB_rd_dt = d;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            m_data[i]  = 32'hx;
            m_owner[i] = 5'hx;
        end
        idle();
        rst = 1'b0;
        iID_rs1_regnm = 5'd5;
        iID_rs2_regnm = 5'd0;
        @(negedge clk);
        tick();
        tick();

        // Reset state
        rst = 1'b1;
        #1;
        chk("reset_rs1_dt", oRS1_dt, 32'd0);
        chk("reset_rs1_nick", oRS1_nick, 5'd0);
        chk("reset_rs2_dt", oRS2_dt, 32'd0);
        tick();

        // Rename then commit
        rename(5'd3, 5'd7); tick(); idle();
        iID_rs1_regnm = 5'd3;
        #1 chk("ren_nick", oRS1_nick, 5'd7);
        tick();
        commit(5'd3, 5'd7, 32'hDEADBEEF);
        iID_rs2_regnm = 5'd3;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp1_dt", oRS2_dt, 32'hDEADBEEF);
        chk("byp1_nick", oRS2_nick, 5'd0);
`else
        chk("nobyp1_nick", oRS2_nick, 5'd7);
`endif
        tick(); idle();
        #1;
        chk("commit_dt", oRS1_dt, 32'hDEADBEEF);
        chk("commit_nick", oRS1_nick, 5'd0);
        tick();

        // Stale commit keeps the younger owner
        rename(5'd4, 5'd2); tick(); idle();
        rename(5'd4, 5'd9); tick(); idle();
        commit(5'd4, 5'd2, 32'h11); tick(); idle();
        iID_rs1_regnm = 5'd4;
        #1;
        chk("stale_dt", oRS1_dt, 32'h11);
        chk("stale_nick", oRS1_nick, 5'd9);
        tick();

        // Same-cycle rename and commit
        rename(5'd6, 5'd5); tick(); idle();
        rename(5'd6, 5'd12); commit(5'd6, 5'd5, 32'h22); tick(); idle();
        iID_rs1_regnm = 5'd6;
        #1;
        chk("rc_dt", oRS1_dt, 32'h22);
        chk("rc_nick", oRS1_nick, 5'd12);
        tick();
        rename(5'd0, 5'd3); commit(5'd0, 5'd0, 32'h55); tick(); idle();
        iID_rs1_regnm = 5'd0;
        #1;
        chk("x0_dt", oRS1_dt, 32'd0);
        chk("x0_nick", oRS1_nick, 5'd0);
        tick();

        // Clear with concurrent commit and rename
        rename(5'd1, 5'd3); tick(); idle();
        rename(5'd2, 5'd4); tick(); idle();
        iROB_clr = 1'b1; commit(5'd1, 5'd3, 32'h33); rename(5'd8, 5'd5); tick(); idle();
        iID_rs1_regnm = 5'd1; iID_rs2_regnm = 5'd2;
        #1;
        chk("clr_x1_dt", oRS1_dt, 32'h33);
        chk("clr_x1_nick", oRS1_nick, 5'd0);
        chk("clr_x2_dt", oRS2_dt, 32'd0);
        chk("clr_x2_nick", oRS2_nick, 5'd0);
        tick();
        iID_rs1_regnm = 5'd8;
        #1 chk("clr_x8_nick", oRS1_nick, 5'd0);
        tick();

        // Same-cycle forwarding (or not)
        rename(5'd3, 5'd7); tick(); idle();
        commit(5'd3, 5'd7, 32'h44); iID_rs2_regnm = 5'd3;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp2_dt", oRS2_dt, 32'h44);
        chk("byp2_nick", oRS2_nick, 5'd0);
`else
        chk("nobyp2_dt", oRS2_dt, 32'hDEADBEEF);
        chk("nobyp2_nick", oRS2_nick, 5'd7);
`endif
        tick(); idle();

        // Randomized traffic against the model
        for (int k = 0; k < 600; k++) begin
            logic [4:0] r;
            rst = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            rdy = ($urandom_range(0, 9) != 0);
            iROB_clr = ($urandom_range(0, 19) == 0);
            iROB_nick_en = $urandom_range(0, 1);
            iROB_nick_regnm = 5'($urandom_range(0, 7));
            iROB_nick = 5'($urandom_range(1, 31));
            iROB_en = $urandom_range(0, 1);
            r = 5'($urandom_range(0, 7));
            iROB_rd_regnm = r;
            iROB_rd_dt = $urandom;
            iROB_rd_nick = ($urandom_range(0, 3) != 0) ? m_owner[r] : 5'($urandom_range(1, 31));
            iID_rs1_regnm = ($urandom_range(0, 1) != 0) ? r : 5'($urandom_range(0, 7));
            iID_rs2_regnm = 5'($urandom_range(0, 31));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
